// File: rtl/s27_bist.sv
// s27_bist: BIST controller for the s27 benchmark.
// Applies an initialising vector, then LFSR patterns to G0..G3, compacts
// the G17 response into an 8-bit SISR and compares it with GOLDEN at the end.
module s27_bist #(
    parameter int unsigned NPAT     = 15,
    parameter logic [3:0]  SEED     = 4'b0001,
    parameter logic [7:0]  GOLDEN   = 8'h00,
    parameter int unsigned INIT_CYC = 2
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       START,
    input  logic       G17,
    output logic       G0,
    output logic       G1,
    output logic       G2,
    output logic       G3,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] SIG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] NPAT_LAST = 8'(NPAT - 1);
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYC - 1);
    localparam logic [3:0] INIT_VEC  = 4'b0011;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_p;
    logic [3:0] w_p_nxt;
    logic [7:0] r_sig;
    logic [7:0] w_sig_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_pass_nxt;

    // Next-state, pattern, signature and counter update; status outputs are
    // derived from the next state so that they come straight out of flops.
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_sig_nxt   = r_sig;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_state_nxt = S_INIT;
                    w_p_nxt     = INIT_VEC;
                    w_sig_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_INIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_state_nxt = S_APPLY;
                    w_p_nxt     = SEED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_APPLY: begin
                w_sig_nxt = {r_sig[6:0], r_sig[7] ^ r_sig[5] ^ r_sig[4] ^ r_sig[3] ^ G17};
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == NPAT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_p_nxt     = '0;
                end else begin
                    w_p_nxt = {r_p[2:0], r_p[3] ^ r_p[2]};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_p_nxt     = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_INIT) || (w_state_nxt == S_APPLY);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_pass_nxt = w_done_nxt && (w_sig_nxt == GOLDEN);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_sig   <= w_sig_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign G0   = r_p[0];
    assign G1   = r_p[1];
    assign G2   = r_p[2];
    assign G3   = r_p[3];
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign PASS = r_pass;
    assign SIG  = r_sig;

endmodule

// File: tb/tb_s27_bist.sv
// Testbench for s27_bist: scoreboard of per-cycle expected outputs, a
// behavioural s27 as the attached CUT, and a software s27/SISR reference.
module tb_s27_bist;

    localparam logic [7:0] GOLD_S27 = 8'h6F;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       g17;
    logic [1:0] g17_mode = 2'd0;   // 0: tie 0, 1: tie 1, 2: real CUT
    logic       stuck = 1'b0;      // stuck-at-0 on G17 while CUT attached
    logic       cut_load = 1'b0;
    logic [2:0] cut_rand = 3'd0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic       d_g0, d_g1, d_g2, d_g3, d_busy, d_done, d_pass;
    logic [7:0] d_sig;
    logic       a_g0, a_g1, a_g2, a_g3, a_busy, a_done, a_pass;
    logic [7:0] a_sig;
    logic       s_g0, s_g1, s_g2, s_g3, s_busy, s_done, s_pass;
    logic [7:0] s_sig;
    logic       n_g0, n_g1, n_g2, n_g3, n_busy, n_done, n_pass;
    logic [7:0] n_sig;

    // Clock
    always #5 CK = ~CK;

    s27_bist u_dut (
        .CK(CK), .RN(RN), .START(START), .G17(g17),
        .G0(d_g0), .G1(d_g1), .G2(d_g2), .G3(d_g3),
        .BUSY(d_busy), .DONE(d_done), .PASS(d_pass), .SIG(d_sig)
    );

    s27_bist #(.GOLDEN(8'h1C)) u_gold (
        .CK(CK), .RN(RN), .START(START), .G17(g17),
        .G0(a_g0), .G1(a_g1), .G2(a_g2), .G3(a_g3),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .SIG(a_sig)
    );

    s27_bist #(.GOLDEN(GOLD_S27)) u_s27 (
        .CK(CK), .RN(RN), .START(START), .G17(g17),
        .G0(s_g0), .G1(s_g1), .G2(s_g2), .G3(s_g3),
        .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .SIG(s_sig)
    );

    s27_bist #(.NPAT(1), .INIT_CYC(3)) u_np1 (
        .CK(CK), .RN(RN), .START(START), .G17(g17),
        .G0(n_g0), .G1(n_g1), .G2(n_g2), .G3(n_g3),
        .BUSY(n_busy), .DONE(n_done), .PASS(n_pass), .SIG(n_sig)
    );

    // Behavioural s27 driven by u_dut; cut_q = {G5, G6, G7}
    logic [2:0] cut_q;
    logic c14, c8, c12, c15, c16, c9, c11, c10, c13, cut_g17;
    always_comb begin
        c14     = ~d_g0;
        c8      = c14 & cut_q[1];
        c12     = ~(d_g1 | cut_q[0]);
        c15     = c12 | c8;
        c16     = d_g3 | c8;
        c9      = ~(c16 & c15);
        c11     = ~(cut_q[2] | c9);
        c10     = ~(c14 | c11);
        c13     = ~(d_g2 | c12);
        cut_g17 = ~c11;
    end

    // CUT flops, with a bench-controlled load to emulate random power-up
    always @(posedge CK) begin
        if (cut_load) cut_q <= cut_rand;
        else          cut_q <= {c10, c11, c13};
    end

    // G17 source selection
    always_comb begin
        case (g17_mode)
            2'd0:    g17 = 1'b0;
            2'd1:    g17 = 1'b1;
            default: g17 = stuck ? 1'b0 : cut_g17;
        endcase
    end

    logic [3:0] pat_tab [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                                 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                                 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [7:0] tr1_tab [15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A,
                                 8'hF4, 8'hE8, 8'hD0, 8'hA1, 8'h43, 8'h87, 8'h0E, 8'h1C};

    typedef struct {
        logic [3:0] g;
        logic       busy;
        logic       done;
        logic       pass;
        logic       chk_sig;
        logic [7:0] sig;
    } exp_t;

    exp_t exp_q[$];

    // Software s27 + SISR reference for the default 15-pattern run
    function automatic logic [7:0] s27_ref(input bit stk);
        logic g5, g6, g7, x0, x1, x2, x3;
        logic t14, t8, t12, t15, t16, t9, t11, t10, t13, r17;
        logic [7:0] s;
        logic [3:0] p;
        g5 = 1'b1; g6 = 1'b0; g7 = 1'b1; s = 8'h00;
        for (int j = 0; j < 15; j++) begin
            p = pat_tab[j];
            x0 = p[0]; x1 = p[1]; x2 = p[2]; x3 = p[3];
            t14 = ~x0;
            t8  = t14 & g6;
            t12 = ~(x1 | g7);
            t15 = t12 | t8;
            t16 = x3 | t8;
            t9  = ~(t16 & t15);
            t11 = ~(g5 | t9);
            t10 = ~(t14 | t11);
            t13 = ~(x2 | t12);
            r17 = stk ? 1'b0 : ~t11;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ r17};
            g5 = t10; g6 = t11; g7 = t13;
        end
        return s;
    endfunction

    // Expected default-parameter schedule; k counts samples after edge E0.
    // sig_mode 0: SIG stays 00, 1: tied-1 trace, 2: only final SIG = fsig
    task automatic push_sched(input int nsamp, input int sig_mode,
                              input logic [7:0] fsig, input logic pass_last);
        exp_t e;
        for (int k = 0; k < nsamp; k++) begin
            e.g       = (k < 2) ? 4'b0011 : (k < 17) ? pat_tab[k-2] : 4'b0000;
            e.busy    = (k < 17);
            e.done    = (k >= 17);
            e.pass    = e.done ? pass_last : 1'b0;
            e.chk_sig = 1'b1;
            e.sig     = 8'h00;
            if (sig_mode == 1) begin
                e.sig = (k < 3) ? 8'h00 : tr1_tab[(k - 3 > 14) ? 14 : k - 3];
            end else if (sig_mode == 2) begin
                e.chk_sig = (k >= 17);
                e.sig     = fsig;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset;
        #1;
        if ({d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h exp 0000",
                     {d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig});
        end
        n_vec++;
        @(negedge CK);
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
    endtask

    task automatic test_sig_tied1;
        exp_t e;
        g17_mode = 2'd1;
        push_sched(18, 1, 8'h00, 1'b0);
        START = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CK);
            if (k == 0) START = 1'b0;
            e = exp_q.pop_front();
            if ({d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig} !==
                {e.g, e.busy, e.done, e.pass, e.sig}) begin
                n_bad++;
                $display("FAIL tied1 k=%0d got %h exp %h", k,
                         {d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig},
                         {e.g, e.busy, e.done, e.pass, e.sig});
            end
            n_vec++;
        end
        if (a_pass !== 1'b1 || a_sig !== 8'h1C) begin
            n_bad++;
            $display("FAIL tied1_golden1c got pass=%b sig=%h exp pass=1 sig=1c", a_pass, a_sig);
        end
        n_vec++;
    endtask

    task automatic test_pattern_order;
        exp_t e;
        g17_mode = 2'd0;
        push_sched(18, 0, 8'h00, 1'b1);
        START = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CK);
            if (k == 0) START = 1'b0;
            e = exp_q.pop_front();
            if ({d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig} !==
                {e.g, e.busy, e.done, e.pass, e.sig}) begin
                n_bad++;
                $display("FAIL pattern k=%0d got %h exp %h", k,
                         {d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig},
                         {e.g, e.busy, e.done, e.pass, e.sig});
            end
            n_vec++;
        end
        if (a_pass !== 1'b0) begin
            n_bad++;
            $display("FAIL tied0_golden1c got pass=%b exp pass=0", a_pass);
        end
        n_vec++;
    endtask

    task automatic test_start_held;
        exp_t e;
        g17_mode = 2'd0;
        push_sched(20, 0, 8'h00, 1'b1);
        START = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CK);
            if (k == 16) START = 1'b0;
            e = exp_q.pop_front();
            if ({d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig} !==
                {e.g, e.busy, e.done, e.pass, e.sig}) begin
                n_bad++;
                $display("FAIL start_held k=%0d got %h exp %h", k,
                         {d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig},
                         {e.g, e.busy, e.done, e.pass, e.sig});
            end
            n_vec++;
        end
    endtask

    task automatic test_s27_run(input bit stk);
        exp_t       e;
        logic [7:0] ref_sig;
        ref_sig  = s27_ref(stk);
        g17_mode = 2'd2;
        stuck    = stk;
        cut_rand = 3'($urandom_range(0, 7));
        cut_load = 1'b1;
        @(negedge CK);
        cut_load = 1'b0;
        push_sched(18, 2, ref_sig, ref_sig == GOLD_S27);
        START = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CK);
            if (k == 0) START = 1'b0;
            e = exp_q.pop_front();
            if ({s_g3, s_g2, s_g1, s_g0, s_busy, s_done, s_pass, e.chk_sig ? s_sig : 8'h00} !==
                {e.g, e.busy, e.done, e.pass, e.chk_sig ? e.sig : 8'h00}) begin
                n_bad++;
                $display("FAIL s27_run stuck=%0d pwr=%0d k=%0d got %h exp %h", stk, cut_rand, k,
                         {s_g3, s_g2, s_g1, s_g0, s_busy, s_done, s_pass, s_sig},
                         {e.g, e.busy, e.done, e.pass, e.sig});
            end
            n_vec++;
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_apply;
        exp_t e;
        g17_mode = 2'd1;
        START = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CK);
            if (k == 0) START = 1'b0;
        end
        #2 RN = 1'b0;
        #1;
        if ({d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_mid_apply got %h exp 0000",
                     {d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig});
        end
        n_vec++;
        @(negedge CK);
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        push_sched(18, 1, 8'h00, 1'b0);
        START = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CK);
            if (k == 0) START = 1'b0;
            e = exp_q.pop_front();
            if ({d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig} !==
                {e.g, e.busy, e.done, e.pass, e.sig}) begin
                n_bad++;
                $display("FAIL post_reset k=%0d got %h exp %h", k,
                         {d_g3, d_g2, d_g1, d_g0, d_busy, d_done, d_pass, d_sig},
                         {e.g, e.busy, e.done, e.pass, e.sig});
            end
            n_vec++;
        end
    endtask

    // NPAT=1, INIT_CYC=3: three INIT cycles, one capture, DONE four edges after START
    task automatic test_npat1;
        exp_t e;
        g17_mode = 2'd1;
        for (int k = 0; k < 6; k++) begin
            e.g       = (k < 3) ? 4'b0011 : (k == 3) ? 4'b0001 : 4'b0000;
            e.busy    = (k < 4);
            e.done    = (k >= 4);
            e.pass    = 1'b0;
            e.chk_sig = 1'b1;
            e.sig     = (k >= 4) ? 8'h01 : 8'h00;
            exp_q.push_back(e);
        end
        START = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CK);
            if (k == 0) START = 1'b0;
            e = exp_q.pop_front();
            if ({n_g3, n_g2, n_g1, n_g0, n_busy, n_done, n_pass, n_sig} !==
                {e.g, e.busy, e.done, e.pass, e.sig}) begin
                n_bad++;
                $display("FAIL npat1 k=%0d got %h exp %h", k,
                         {n_g3, n_g2, n_g1, n_g0, n_busy, n_done, n_pass, n_sig},
                         {e.g, e.busy, e.done, e.pass, e.sig});
            end
            n_vec++;
        end
    endtask

    initial begin
        test_reset();
        test_sig_tied1();
        test_pattern_order();
        test_start_held();
        test_s27_run(1'b0);
        test_s27_run(1'b0);
        test_s27_run(1'b1);
        test_reset_mid_apply();
        test_npat1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
